// File: rtl/execute_mc_if.sv
// ID/EX-to-EX/MEM bundle for the execute stage: control, operands,
// forwarding taps, redirect outputs and the registered EX/MEM fields.
interface execute_mc_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              flush_i;
  logic              stall_i;
  logic              valid_i;
  logic [XLEN-1:0]   rs1_data_i;
  logic [XLEN-1:0]   rs2_data_i;
  logic [XLEN-1:0]   imm_i;
  logic [XLEN-1:0]   pc_i;
  logic [XLEN-1:0]   fwd_mem_i;
  logic [XLEN-1:0]   fwd_wb_i;
  logic [1:0]        fwd_sel_a_i;
  logic [1:0]        fwd_sel_b_i;
  logic [3:0]        alu_op_i;
  logic              imm_sel_i;
  logic [1:0]        br_type_i;
  logic [2:0]        br_cond_i;
  logic              reg_we_i;
  logic              mem_we_i;
  logic [1:0]        wb_sel_i;
  logic [REG_AW-1:0] rd_i;
  logic              ex_ready_o;
  logic              br_taken_o;
  logic [XLEN-1:0]   br_target_o;
  logic [XLEN-1:0]   result_o;
  logic [XLEN-1:0]   store_data_o;
  logic              reg_we_o;
  logic              mem_we_o;
  logic [1:0]        wb_sel_o;
  logic [REG_AW-1:0] rd_o;

  modport master (
    output flush_i, stall_i, valid_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           fwd_mem_i, fwd_wb_i, fwd_sel_a_i, fwd_sel_b_i, alu_op_i, imm_sel_i,
           br_type_i, br_cond_i, reg_we_i, mem_we_i, wb_sel_i, rd_i,
    input  ex_ready_o, br_taken_o, br_target_o, result_o, store_data_o,
           reg_we_o, mem_we_o, wb_sel_o, rd_o
  );

  modport slave (
    input  flush_i, stall_i, valid_i, rs1_data_i, rs2_data_i, imm_i, pc_i,
           fwd_mem_i, fwd_wb_i, fwd_sel_a_i, fwd_sel_b_i, alu_op_i, imm_sel_i,
           br_type_i, br_cond_i, reg_we_i, mem_we_i, wb_sel_i, rd_i,
    output ex_ready_o, br_taken_o, br_target_o, result_o, store_data_o,
           reg_we_o, mem_we_o, wb_sel_o, rd_o
  );
endinterface

// File: rtl/execute_mc.sv
// Execute stage: operand forwarding, single-cycle ALU, branch resolution,
// iterative shift-add multiplier and the EX/MEM pipeline register.
module execute_mc #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int MUL_EN = 1
) (
  input logic         clk_i,
  input logic         rst_n_i,
  execute_mc_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]      state;
  logic [XLEN-1:0] mcand, mplier, acc, product;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] op_a, op_bf, op_b, alu_res, ex_result;
  logic [XLEN-1:0] pc_imm, jalr_sum;
  logic [CW-1:0]   shamt;
  logic            is_mul, mul_start, mul_last, ex_ready, cond_true;

  always_comb begin
    case (bus.fwd_sel_a_i)
      2'd1:    op_a = bus.fwd_mem_i;
      2'd2:    op_a = bus.fwd_wb_i;
      default: op_a = bus.rs1_data_i;
    endcase
    case (bus.fwd_sel_b_i)
      2'd1:    op_bf = bus.fwd_mem_i;
      2'd2:    op_bf = bus.fwd_wb_i;
      default: op_bf = bus.rs2_data_i;
    endcase
    op_b = bus.imm_sel_i ? bus.imm_i : op_bf;
  end

  // The last partial product is folded in combinationally on the final cycle.
  assign is_mul    = (bus.alu_op_i == 4'd10);
  assign mul_start = (state == IDLE) && bus.valid_i && is_mul && (MUL_EN != 0) && !bus.flush_i;
  assign mul_last  = (state == BUSY) && (cnt == CNT_LAST);
  assign product   = acc + (mplier[0] ? mcand : '0);
  assign ex_ready  = !mul_start && !((state == BUSY) && !mul_last);
  assign shamt     = op_b[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.alu_op_i)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = op_a << shamt;
      4'd6:  alu_res = op_a >> shamt;
      4'd7:  alu_res = $signed(op_a) >>> shamt;
      4'd8:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      4'd9:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_bf) || (bus.imm_sel_i && (op_a < op_b))};
      4'd10: alu_res = (MUL_EN != 0) ? product : '0;
      default: alu_res = '0;
    endcase
    if (bus.alu_op_i == 4'd9) alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
  end

  always_comb begin
    cond_true = 1'b0;
    case (bus.br_cond_i)
      3'd0: cond_true = (op_a == op_bf);
      3'd1: cond_true = (op_a != op_bf);
      3'd4: cond_true = ($signed(op_a) <  $signed(op_bf));
      3'd5: cond_true = ($signed(op_a) >= $signed(op_bf));
      3'd6: cond_true = (op_a <  op_bf);
      3'd7: cond_true = (op_a >= op_bf);
      default: cond_true = 1'b0;
    endcase
  end

  assign pc_imm   = bus.pc_i + bus.imm_i;
  assign jalr_sum = op_a + bus.imm_i;
  assign bus.br_taken_o  = bus.valid_i && !bus.flush_i &&
                           ((bus.br_type_i == 2'd1) ? cond_true : (bus.br_type_i != 2'd0));
  assign bus.br_target_o = (bus.br_type_i == 2'd3) ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;
  assign bus.ex_ready_o  = ex_ready;
  assign ex_result = (bus.br_type_i[1]) ? bus.pc_i + XLEN'(4) : alu_res;

  // Stall freezes the multiplier in BUSY but never blocks a multiply from starting.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (bus.flush_i) begin
      state <= IDLE;
    end else if (mul_start) begin
      mcand  <= op_a;
      mplier <= op_b;
      acc    <= '0;
      cnt    <= '0;
      state  <= BUSY;
    end else if ((state == BUSY) && !bus.stall_i) begin
      if (mul_last) begin
        state <= IDLE;
      end else begin
        acc    <= product;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bus.result_o     <= '0;
      bus.store_data_o <= '0;
      bus.reg_we_o     <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.wb_sel_o     <= '0;
      bus.rd_o         <= '0;
    end else if (bus.flush_i || !bus.stall_i) begin
      bus.result_o     <= ex_result;
      bus.store_data_o <= op_bf;
      bus.wb_sel_o     <= bus.wb_sel_i;
      bus.rd_o         <= bus.rd_i;
      bus.reg_we_o     <= !bus.flush_i && bus.valid_i && ex_ready && bus.reg_we_i;
      bus.mem_we_o     <= !bus.flush_i && bus.valid_i && ex_ready && bus.mem_we_i;
    end
  end
endmodule

// File: tb/tb_execute_mc.sv
// Directed self-checking bench for execute_mc at XLEN=32.
module tb_execute_mc;
  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   edges;
  int   we_seen;
  logic [31:0] held;

  execute_mc_if #(.XLEN(32), .REG_AW(5)) bus ();

  execute_mc #(.XLEN(32), .REG_AW(5), .MUL_EN(1)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic imm_sel);
    bus.valid_i     = 1'b1;
    bus.alu_op_i    = op;
    bus.rs1_data_i  = rs1;
    bus.rs2_data_i  = rs2;
    bus.imm_i       = imm;
    bus.imm_sel_i   = imm_sel;
    bus.fwd_sel_a_i = 2'd0;
    bus.fwd_sel_b_i = 2'd0;
    bus.br_type_i   = 2'd0;
    bus.br_cond_i   = 3'd0;
    bus.reg_we_i    = 1'b1;
    bus.mem_we_i    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.flush_i = 0; bus.stall_i = 0; bus.valid_i = 0;
    bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.imm_i = 0; bus.pc_i = 0;
    bus.fwd_mem_i = 0; bus.fwd_wb_i = 0; bus.fwd_sel_a_i = 0; bus.fwd_sel_b_i = 0;
    bus.alu_op_i = 0; bus.imm_sel_i = 0; bus.br_type_i = 0; bus.br_cond_i = 0;
    bus.reg_we_i = 0; bus.mem_we_i = 0; bus.wb_sel_i = 0; bus.rd_i = 0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_result", bus.result_o, 32'h0);
    checkOutput("reset_reg_we", {31'b0, bus.reg_we_o}, 32'h0);
    checkOutput("reset_ex_ready", {31'b0, bus.ex_ready_o}, 32'h1);
    tick();
    rst_n = 1'b1;

    // Forwarding from MEM into A, immediate as B
    applyStimulus(4'd0, 32'd5, 32'h11, 32'd3, 1'b1);
    bus.fwd_mem_i = 32'd9; bus.fwd_sel_a_i = 2'd1; bus.rd_i = 5'd7;
    bus.wb_sel_i = 2'd2; bus.mem_we_i = 1'b1;
    #1 checkOutput("fwd_ex_ready", {31'b0, bus.ex_ready_o}, 32'h1);
    tick();
    checkOutput("fwd_add_result", bus.result_o, 32'd12);
    checkOutput("fwd_reg_we", {31'b0, bus.reg_we_o}, 32'h1);
    checkOutput("fwd_mem_we", {31'b0, bus.mem_we_o}, 32'h1);
    checkOutput("fwd_rd", {27'b0, bus.rd_o}, 32'd7);
    checkOutput("fwd_wb_sel", {30'b0, bus.wb_sel_o}, 32'd2);
    checkOutput("fwd_store_data", bus.store_data_o, 32'h11);

    applyStimulus(4'd1, 32'd5, 32'd9, 32'd0, 1'b0);
    tick();
    checkOutput("sub_wrap", bus.result_o, 32'hFFFF_FFFC);
    applyStimulus(4'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
    tick();
    checkOutput("sra", bus.result_o, 32'hF800_0000);
    applyStimulus(4'd5, 32'h0000_0001, 32'd33, 32'd0, 1'b0);
    tick();
    checkOutput("sll_low_bits", bus.result_o, 32'h0000_0002);
    applyStimulus(4'd8, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    checkOutput("slt_signed", bus.result_o, 32'd0);
    applyStimulus(4'd9, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    tick();
    checkOutput("sltu_unsigned", bus.result_o, 32'd1);
    applyStimulus(4'd4, 32'hF0F0_0000, 32'h0, 32'd0, 1'b0);
    bus.fwd_wb_i = 32'h0FF0_00AA; bus.fwd_sel_b_i = 2'd2;
    tick();
    checkOutput("xor_fwd_wb", bus.result_o, 32'hFF00_00AA);
    checkOutput("store_fwd_wb", bus.store_data_o, 32'h0FF0_00AA);
    applyStimulus(4'd12, 32'h1234, 32'h5678, 32'd0, 1'b0);
    bus.valid_i = 1'b0;
    tick();
    checkOutput("undef_op_zero", bus.result_o, 32'd0);
    checkOutput("invalid_no_we", {31'b0, bus.reg_we_o}, 32'h0);

    // Multiply 0xFFFFFFFF * 3
    applyStimulus(4'd10, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b0);
    #1;
    edges = 0; we_seen = 0;
    while (bus.ex_ready_o == 1'b0 && edges < 40) begin
      tick();
      edges++;
      if (bus.reg_we_o) we_seen++;
    end
    checkOutput("mul_ready_low_cycles", edges, 32'd32);
    checkOutput("mul_no_early_we", we_seen, 32'd0);
    tick();
    checkOutput("mul_product", bus.result_o, 32'hFFFF_FFFD);
    checkOutput("mul_we_once", {31'b0, bus.reg_we_o}, 32'h1);
    bus.valid_i = 1'b0;
    tick();
    checkOutput("mul_we_drop", {31'b0, bus.reg_we_o}, 32'h0);

    // Flush at cnt=10
    applyStimulus(4'd10, 32'd7, 32'd6, 32'd0, 1'b0);
    repeat (11) tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    #1;
    checkOutput("flush_reg_we", {31'b0, bus.reg_we_o}, 32'h0);
    checkOutput("flush_ex_ready", {31'b0, bus.ex_ready_o}, 32'h1);
    we_seen = 0;
    repeat (35) begin
      tick();
      if (bus.reg_we_o) we_seen++;
    end
    checkOutput("flush_no_product_we", we_seen, 32'd0);

    // Stall three cycles at cnt=31
    applyStimulus(4'd10, 32'h1234, 32'h10, 32'd0, 1'b0);
    repeat (32) tick();
    checkOutput("stall_ready_at_last", {31'b0, bus.ex_ready_o}, 32'h1);
    bus.stall_i = 1'b1;
    held = bus.result_o;
    repeat (3) begin
      tick();
      checkOutput("stall_hold_result", bus.result_o, held);
      checkOutput("stall_hold_we", {31'b0, bus.reg_we_o}, 32'h0);
      checkOutput("stall_ready_high", {31'b0, bus.ex_ready_o}, 32'h1);
    end
    bus.stall_i = 1'b0;
    tick();
    checkOutput("stall_product", bus.result_o, 32'h0001_2340);
    checkOutput("stall_we_once", {31'b0, bus.reg_we_o}, 32'h1);
    bus.valid_i = 1'b0;
    tick();
    checkOutput("stall_we_drop", {31'b0, bus.reg_we_o}, 32'h0);

    // Branches
    applyStimulus(4'd0, 32'hFFFF_FFFF, 32'd1, 32'h20, 1'b0);
    bus.pc_i = 32'h100; bus.br_type_i = 2'd1; bus.br_cond_i = 3'd4;
    #1;
    checkOutput("blt_taken", {31'b0, bus.br_taken_o}, 32'h1);
    checkOutput("blt_target", bus.br_target_o, 32'h120);
    bus.br_cond_i = 3'd5;
    #1 checkOutput("bge_not_taken", {31'b0, bus.br_taken_o}, 32'h0);
    bus.br_cond_i = 3'd6;
    #1 checkOutput("bltu_not_taken", {31'b0, bus.br_taken_o}, 32'h0);
    bus.br_cond_i = 3'd2;
    #1 checkOutput("cond2_never", {31'b0, bus.br_taken_o}, 32'h0);
    bus.br_cond_i = 3'd4; bus.flush_i = 1'b1;
    #1 checkOutput("flush_kills_branch", {31'b0, bus.br_taken_o}, 32'h0);
    bus.flush_i = 1'b0; bus.valid_i = 1'b0;
    #1 checkOutput("invalid_kills_branch", {31'b0, bus.br_taken_o}, 32'h0);
    bus.valid_i = 1'b1; bus.br_type_i = 2'd2;
    #1;
    checkOutput("jal_taken", {31'b0, bus.br_taken_o}, 32'h1);
    checkOutput("jal_target", bus.br_target_o, 32'h120);
    applyStimulus(4'd0, 32'h203, 32'd0, 32'd0, 1'b1);
    bus.pc_i = 32'h400; bus.br_type_i = 2'd3;
    #1;
    checkOutput("jalr_taken", {31'b0, bus.br_taken_o}, 32'h1);
    checkOutput("jalr_target", bus.br_target_o, 32'h202);
    tick();
    checkOutput("jalr_link", bus.result_o, 32'h404);

    // Reset at cnt=5
    applyStimulus(4'd10, 32'd3, 32'd5, 32'd0, 1'b0);
    bus.rd_i = 5'd9;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_result", bus.result_o, 32'h0);
    checkOutput("rst_mid_store", bus.store_data_o, 32'h0);
    checkOutput("rst_mid_rd", {27'b0, bus.rd_o}, 32'h0);
    checkOutput("rst_mid_we", {31'b0, bus.reg_we_o}, 32'h0);
    bus.valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 checkOutput("rst_release_ready", {31'b0, bus.ex_ready_o}, 32'h1);
    tick();
    checkOutput("rst_release_idle", {31'b0, bus.ex_ready_o}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised execute stage: forwarding muxes, single-cycle ALU, branch resolution, iterative shift-add multiplier, EX/MEM pipeline register.
- Sits between the ID/EX register and the memory stage.
- Stalls upstream through ex_ready_o while a multiply is in flight; replaces the fixed-width, fixed-accelerator execute stage.

Parameters:
XLEN, 32, datapath width (>=8, power of 2)
REG_AW, 5, register index width
MUL_EN, 1, 1 = iterative multiplier present; 0 = MUL op returns 0 in one cycle

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  kill instruction in EX and write a bubble into EX/MEM
stall_i  in  1  downstream stall; hold EX/MEM and multiplier state
valid_i  in  1  ID/EX holds a real instruction
rs1_data_i, rs2_data_i, imm_i, pc_i  in  XLEN  operands, immediate, instruction PC
fwd_mem_i, fwd_wb_i  in  XLEN  forwarded data from MEM and WB stages
fwd_sel_a_i, fwd_sel_b_i  in  2  0 = reg, 1 = MEM, 2 = WB, 3 = reg
alu_op_i  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 MUL; 11-15 give result 0
imm_sel_i  in  1  ALU operand B = imm_i
br_type_i  in  2  0 none, 1 conditional, 2 JAL, 3 JALR
br_cond_i  in  3  0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2, 3 never taken
reg_we_i, mem_we_i  in  1  control for MEM/WB
wb_sel_i  in  2  writeback select, passed through
rd_i  in  REG_AW  destination register
ex_ready_o  out  1  combinational; 0 = upstream must hold ID/EX
br_taken_o  out  1  combinational; taken redirect
br_target_o  out  XLEN  combinational; redirect PC
result_o, store_data_o  out  XLEN  EX/MEM: ALU result, forwarded rs2
reg_we_o, mem_we_o  out  1  EX/MEM write enables
wb_sel_o  out  2  EX/MEM
rd_o  out  REG_AW  EX/MEM

Behaviour:
- Operands:
  - A = fwd(rs1, fwd_sel_a_i).
  - Bf = fwd(rs2, fwd_sel_b_i).
  - B = imm_sel_i ? imm_i : Bf.
  - store_data_o captures Bf.
- ALU: all arithmetic mod 2^XLEN. Shifts use B[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1. MUL returns the low XLEN bits of the product; signedness is irrelevant.
- Branch (compares A against Bf):
  - Type 1 taken when the cond holds; target pc_i+imm_i.
  - JAL always taken; target pc_i+imm_i.
  - JALR always taken; target (A+imm_i) with bit0 cleared.
  - br_taken_o is gated by valid_i and forced 0 when flush_i=1.
  - For JAL/JALR, result = pc_i+4.
- FSM states: IDLE, BUSY. Registers: multiplicand, multiplier, accumulator, counter cnt of width log2(XLEN).
  - IDLE, valid_i & MUL & MUL_EN & !flush_i: ex_ready_o=0, EX/MEM loads bubble (or holds if stall_i). At the edge, capture A, B, acc=0, cnt=0, go to BUSY.
  - BUSY: each edge, acc += mcand if mplier[0]; mcand<<=1; mplier>>=1; cnt++.
  - ex_ready_o=0 while cnt<XLEN-1.
  - At cnt==XLEN-1: ex_ready_o=1, final sum combinational. If !stall_i, EX/MEM loads product and FSM returns to IDLE; else hold all state.
- Multiply timing: ex_ready_o is low for exactly XLEN cycles. result_o shows the product after the (XLEN+1)th rising edge counted from first presentation (33 edges at XLEN=32).
- Non-MUL (or MUL_EN=0): ex_ready_o=1; result_o updates at the next edge; latency 1.
- EX/MEM update priority: flush_i > stall_i > load.
  - flush_i: reg_we_o=0, mem_we_o=0; data fields load don't-care values; FSM returns to IDLE, aborting any multiply.
  - stall_i: all EX/MEM outputs hold.
  - Load with valid_i=0 or ex_ready_o=0: write enables 0.
- Reset (asynchronous): all EX/MEM outputs 0, FSM IDLE, counters 0. Reset mid-multiply abandons the multiply.
- stall_i during IDLE with a MUL presented: the multiply still starts; stall only freezes EX/MEM.

Test Plan:
- Forwarding: rs1=5, fwd_mem=9, sel_a=1, ADD, imm_sel=1, imm=3 -> result_o=12 after 1 edge, reg_we_o=1.
- Multiply, XLEN=32: A=0xFFFF_FFFF, B=3, MUL -> ex_ready_o low 32 cycles, result_o=0xFFFF_FFFD after edge 33, reg_we_o=1 once.
- Flush mid-multiply: flush_i at BUSY cnt=10 -> FSM IDLE, reg_we_o=0, ex_ready_o=1 next cycle, no product written.
- Stall on final multiply cycle: stall_i high 3 cycles at cnt=31 -> outputs held, product loaded on first non-stalled edge, exactly once.
- Branches: BLT A=-1, Bf=1, pc=0x100, imm=0x20 -> br_taken_o=1, target 0x120. JALR A=0x203, imm=0 -> target 0x202, result_o=pc+4.
- Reset: assert rst_n_i low at BUSY cnt=5 -> all outputs 0 immediately, FSM IDLE, ex_ready_o=1 after release.
